// File: rtl/eeprom_bus_bridge.sv
// eeprom_bus_bridge: posts 16-bit CPU writes into a FIFO drained onto a byte-wide EEPROM.
// Reads are serialised behind queued writes, which gives read-after-write ordering.
module eeprom_bus_bridge #(
  parameter int FIFO_DEPTH  = 4,
  parameter bit STALL_READS = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [12:0] cpu_addr,
  input  logic [15:0] cpu_din,
  input  logic [1:0]  cpu_be,
  output logic [15:0] cpu_dout,
  output logic        cpu_ack,
  output logic        ee_wr,
  output logic        ee_rd,
  output logic [12:0] ee_addr,
  output logic [7:0]  ee_data,
  input  logic [7:0]  ee_q,
  input  logic        ee_ready,
  output logic        pending
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT, RD_ADDR, RD_DATA} state_t;
  state_t state, next;
  logic [20:0] fifo [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic served, full, pop, push, wr_take, rd_take, issue;
  logic unused_bits;
  assign unused_bits = ^{cpu_din[15:8], cpu_be[1]};
  // a pop in the same cycle frees a slot, so a full FIFO can still take the retried write
  always_comb begin
    full = count == (AW+1)'(FIFO_DEPTH);
    pop = state == ISSUE;
    wr_take = !served && cpu_wr && (!cpu_be[0] || !full || pop);
    push = wr_take && cpu_be[0];
    rd_take = !served && cpu_rd && !cpu_wr && state == IDLE && count == '0 && (ee_ready || !STALL_READS);
    issue = state == IDLE && count != '0 && ee_ready;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= next;
  // SETTLE skips one cycle because ee_ready reacts to ee_wr a clock late
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = rd_take ? RD_ADDR : issue ? ISSUE : IDLE;
      ISSUE:   next = SETTLE;
      SETTLE:  next = WAIT;
      WAIT:    next = ee_ready ? IDLE : WAIT;
      RD_ADDR: next = RD_DATA;
      RD_DATA: next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    ee_wr = state == ISSUE;
    ee_rd = state == RD_ADDR;
    pending = count != '0 || state == ISSUE || state == SETTLE || state == WAIT;
  end
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= {cpu_addr, cpu_din[7:0]};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      served <= 1'b0;
      cpu_ack <= 1'b0;
      cpu_dout <= '0;
      ee_addr <= '0;
      ee_data <= '0;
    end else begin
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      served <= (wr_take || rd_take) ? 1'b1 : (!cpu_rd && !cpu_wr) ? 1'b0 : served;
      cpu_ack <= wr_take || state == RD_DATA;
      if (state == RD_DATA) cpu_dout <= {8'hFF, ee_q};
      if (issue) {ee_addr, ee_data} <= fifo[rd_ptr];
      else if (rd_take) ee_addr <= cpu_addr;
    end
endmodule
